// File: rtl/md_pkg.sv
// Shared constants for the EX-stage datapath: MD operation codes plus small
// helpers that classify them.
//   MD_* : 4-bit op codes driven on md_unit.op
//   md_is_mult / md_is_div : true for the multi-cycle op classes
package md_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  function automatic logic md_is_mult(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide core.
//   op     : MD op code (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b   : rs / rt operands
//   hi_res : product upper half, or remainder
//   lo_res : product lower half, or quotient
// Non-mult/div op codes give zero results.
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;
  logic               signed_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   div_b;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;

  always_comb begin
    // Extending both operands to 2*WIDTH and keeping the low 2*WIDTH bits of
    // the product yields the exact two's-complement product for signed ops.
    mul_a   = (op == MD_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    mul_b   = (op == MD_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    product = mul_a * mul_b;

    // Signed divide runs on magnitudes; the most-negative value's magnitude
    // is representable as unsigned, so MIN / -1 naturally wraps back to MIN.
    signed_div = (op == MD_DIV);
    mag_a      = (signed_div && a[WIDTH-1]) ? -a : a;
    mag_b      = (signed_div && b[WIDTH-1]) ? -b : b;
    // Keep the divider away from a zero divisor; that case is muxed out below.
    div_b      = (mag_b == '0) ? WIDTH'(1) : mag_b;
    quo_mag    = mag_a / div_b;
    rem_mag    = mag_a % div_b;

    hi_res = '0;
    lo_res = '0;
    if (md_is_mult(op)) begin
      {hi_res, lo_res} = product;
    end else if (md_is_div(op)) begin
      if (b == '0) begin
        hi_res = a;
        lo_res = '1;
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        lo_res = (signed_div && (a[WIDTH-1] ^ b[WIDTH-1])) ? -quo_mag : quo_mag;
        hi_res = (signed_div && a[WIDTH-1]) ? -rem_mag : rem_mag;
      end
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
//   clk, reset : clock, synchronous active-high reset
//   start      : op/a/b valid this cycle
//   op, a, b   : MD op code and rs/rt operands
//   busy       : a mult/div is in flight
//   hi, lo     : architectural HI/LO
//   out        : hi for MFHI, lo for MFLO, else 0 (combinational)
//
// Handshake: a mult/div is accepted on a rising edge where start=1 and
// busy=0; busy is then high for exactly MULT_CYCLES/DIV_CYCLES cycles and
// hi/lo hold the new result in the first cycle busy is low again. start while
// busy=1 is dropped without side effects. MTHI/MTLO accepted with busy=0 write
// at that same edge and never raise busy. CNT_W must satisfy
// 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES).
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] pend_hi_q;
  logic [WIDTH-1:0] pend_lo_q;
  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_res(hi_res),
    .lo_res(lo_res)
  );

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    out = '0;
    if (op == MD_MFHI) out = hi_q;
    else if (op == MD_MFLO) out = lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else if (busy) begin
      // Any start seen here is dropped; only the countdown advances.
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (start) begin
      if (md_is_mult(op) || md_is_div(op)) begin
        pend_hi_q <= hi_res;
        pend_lo_q <= lo_res;
        cnt_q     <= md_is_mult(op) ? MULT_N : DIV_N;
      end else if (op == MD_MTHI) begin
        hi_q <= a;
      end else if (op == MD_MTLO) begin
        lo_q <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = MD_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo, out;

  int total = 0;
  int bad = 0;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .out(out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Architectural view: a mult/div accepted at edge number e lands at edge
  // e+N; the unit is busy for every edge count strictly before that landing.
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          edge_cnt = 0;
  int          land_at = 0;
  bit          check_en = 0;

  function automatic logic [63:0] ref_calc(input logic [3:0] o,
                                           input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    res = '0;
    if (o == MD_MULT) res = 64'(sx * sy);
    else if (o == MD_MULTU) res = ux * uy;
    else if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
    else if (o == MD_DIV) begin
      q = sx / sy;
      r = sx % sy;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {x % y, x / y};
    end
    return res;
  endfunction

  always @(posedge clk) begin
    bit was_busy;
    logic [63:0] r;
    was_busy = (edge_cnt < land_at);
    edge_cnt++;
    if (reset) begin
      m_hi = '0; m_lo = '0; land_at = 0; exp_q.delete();
    end else if (was_busy) begin
      if (edge_cnt == land_at) begin
        r = exp_q.pop_front();
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end else if (start) begin
      if (op == MD_MULT || op == MD_MULTU) begin
        exp_q.push_back(ref_calc(op, a, b));
        land_at = edge_cnt + 5;
      end else if (op == MD_DIV || op == MD_DIVU) begin
        exp_q.push_back(ref_calc(op, a, b));
        land_at = edge_cnt + 10;
      end else if (op == MD_MTHI) m_hi = a;
      else if (op == MD_MTLO) m_lo = a;
    end
    check_en = 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("sb_busy", {31'b0, busy}, {31'b0, (edge_cnt < land_at)});
      check("sb_hi", hi, m_hi);
      check("sb_lo", lo, m_lo);
      check("sb_out", out, (op == MD_MFHI) ? m_hi : (op == MD_MFLO) ? m_lo : 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #2;
    start = 1'b0; op = MD_NONE; a = '0; b = '0;
  endtask

  // Called just after the accepting edge; returns the number of busy cycles.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #2;
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                        input logic [31:0] y, input int n_exp,
                        input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    issue(o, x, y);
    wait_idle(n);
    check({name, "_cycles"}, n, n_exp);
    check({name, "_hi"}, hi, hi_exp);
    check({name, "_lo"}, lo, lo_exp);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);

    run_op("mult_neg", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    run_op("div_zero", MD_DIV, 32'hFFFF_FFF0, 32'd0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

    issue(MD_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_busy", {31'b0, busy}, 32'h0);
    check("mthi_hi", hi, 32'h1234_5678);
    op = MD_MFHI; #1;
    check("mfhi_out", out, 32'h1234_5678);
    issue(MD_MTLO, 32'hCAFE_F00D, 32'h0);
    check("mtlo_busy", {31'b0, busy}, 32'h0);
    op = MD_MFLO; #1;
    check("mflo_out", out, 32'hCAFE_F00D);
    op = MD_NONE;

    // Reset during busy cycle 3 discards the in-flight product.
    issue(MD_MULT, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    check("rst_mid_hi", hi, 32'h0);
    check("rst_mid_lo", lo, 32'h0);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    repeat (8) @(posedge clk);
    #2 check("rst_mid_nolate", lo, 32'h0);

    // start with MULT during DIV busy cycle 2 must be ignored.
    issue(MD_DIV, 32'd100, 32'd7);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin start = 1'b1; op = MD_MULT; a = 32'd5; b = 32'd5; end
      else begin start = 1'b0; op = MD_NONE; a = '0; b = '0; end
      @(posedge clk); #2;
    end
    start = 1'b0; op = MD_NONE; a = '0; b = '0;
    check("ign_cycles", n, 10);
    check("ign_lo", lo, 32'd14);
    check("ign_hi", hi, 32'd2);
    repeat (6) @(posedge clk);
    #2 check("ign_busy_after", {31'b0, busy}, 32'h0);
    check("ign_lo_after", lo, 32'd14);

    // Randomized traffic, checked every cycle by the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #2;
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 10));
      a     = rand_operand();
      b     = rand_operand();
    end
    @(posedge clk); #2;
    start = 1'b0; reset = 1'b0; op = MD_NONE;
    wait_idle(n);
    check("final_idle", {31'b0, busy}, 32'h0);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
